add_result_acc: RTL and testbench
=================================

ADD_RESULT_ACC -- requirements
Module: add_result_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 8, accumulator width; legal range ACC_W >= 5.
REQ-002 SHALL have parameter N, default 4, samples per batch; legal range N >= 1.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, upstream adder sample valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept a sample.
REQ-007 SHALL have port result, input, 4, 4-bit adder sum.
REQ-008 SHALL have port carry, input, 1, adder carry-out.
REQ-009 SHALL have port clr, input, 1, synchronous batch clear.
REQ-010 SHALL have port out_valid, output, 1, batch total available.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts total.
REQ-012 SHALL have port acc_out, output, ACC_W, batch total.
REQ-013 SHALL have port ovf, output, 1, sticky overflow flag for the current batch.
REQ-014 SHALL have port count, output, $clog2(N+1), samples accepted in the current batch.

Function
REQ-015 SHALL treat each sample as the 5-bit value {carry,result} (0..31), zero-extended to ACC_W.
REQ-016 SHALL implement states IDLE (count=0), ACCUM (0<count<N) and HOLD (batch complete).
REQ-017 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in HOLD.
REQ-018 SHALL accept a sample when in_valid && in_ready: acc <= acc + sample, count <= count+1.
REQ-019 SHALL transition IDLE->ACCUM on the first accept, or IDLE->HOLD when N=1.
REQ-020 SHALL transition ACCUM->HOLD on the Nth accept and assert out_valid on the next cycle.
REQ-021 SHALL hold acc_out, ovf and out_valid stable in HOLD until out_valid && out_ready.
REQ-022 SHALL, on out_valid && out_ready, clear acc, count, ovf and out_valid and enter IDLE; no sample is accepted in that cycle.
REQ-023 SHALL ignore in_valid while in HOLD, with no state change.
REQ-024 SHALL give clr priority over accept and output handshake: acc=0, count=0, ovf=0, out_valid=0, state IDLE.
REQ-025 SHALL register acc_out so it equals the running accumulator at all times; it is meaningful only while out_valid=1.
REQ-026 SHALL set ovf when an addition exceeds 2^ACC_W-1; ovf stays set until clear, handshake or reset.

Reset
REQ-027 SHALL, while rst_n=0, immediately force state=IDLE, acc_out=0, count=0, ovf=0 and out_valid=0; in_ready SHALL be 1 after release.
REQ-028 SHALL abandon any partial or held batch when reset is asserted mid-operation.

Configuration
REQ-029 SHALL use macro ACC_SATURATE_EN: when defined, overflowing sums clamp to 2^ACC_W-1 and stay clamped for the batch; when undefined, sums wrap modulo 2^ACC_W; ovf behaves identically in both cases.

Verification
REQ-030 SHALL check N=4, ACC_W=8 with samples 0x0A, 0x0C, 0x1D, 0x01 -> out_valid one cycle after the 4th accept, acc_out=0x34, ovf=0.
REQ-031 SHALL check ACC_W=6 with four samples of 0x1F -> acc_out=0x3C and ovf=1 without the macro; acc_out=0x3F and ovf=1 with it.
REQ-032 SHALL check out_ready held low 5 cycles in HOLD with in_valid=1 -> acc_out and count stable, in_ready=0, then handshake -> IDLE, count=0.
REQ-033 SHALL check clr after 2 accepts -> count=0, acc=0; the next four samples 1,2,3,4 -> acc_out=0x0A.
REQ-034 SHALL check rst_n pulsed low in HOLD -> out_valid=0, acc_out=0 asynchronously, in_ready=1 after release.
REQ-035 SHALL check in_valid with 1-3 idle gaps between samples -> the same total as back-to-back delivery.

Source files
------------

// File: rtl/add_result_acc.sv
// ---------------------------------------------------------------------------
// add_result_acc
//
// Accumulates batches of N samples from a 4-bit adder. Each sample is
// {carry,result} (0..31), zero-extended to ACC_W. Once N samples have been
// accepted, the block holds the batch total on acc_out with out_valid=1.
// It stops accepting input until the downstream handshake
// (out_valid && out_ready) clears the batch.
//
// Parameters
//   ACC_W : accumulator width (>= 5)
//   N     : samples per batch (>= 1)
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   upstream sample valid
//   in_ready  out  block can accept a sample (low only while holding a total)
//   result    in   4-bit adder sum
//   carry     in   adder carry-out
//   clr       in   synchronous batch clear; beats accept and output handshake
//   out_valid out  batch total available
//   out_ready in   downstream accepts the total
//   acc_out   out  running accumulator / batch total
//   ovf       out  sticky overflow flag for the current batch
//   count     out  samples accepted in the current batch
//
// Configuration
//   ACC_SATURATE_EN : when defined, overflowing sums clamp to 2^ACC_W-1 and
//                     remain clamped for the rest of the batch. When it is
//                     undefined, sums wrap modulo 2^ACC_W. ovf is the same in
//                     both builds.
// ---------------------------------------------------------------------------
module add_result_acc #(
  parameter int ACC_W = 8,
  parameter int N     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             result,
  input  logic                   carry,
  input  logic                   clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       acc_out,
  output logic                   ovf,
  output logic [$clog2(N+1)-1:0] count
);

  localparam int CNT_W = $clog2(N+1);
  // count value at which the next accept completes the batch
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N-1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic             in_ready_q;

  logic [ACC_W:0]   sum_wide;
  logic             add_ovf;
  logic [ACC_W-1:0] acc_d;
  logic             accept;
  logic             last_accept;

  // One extra bit on the adder catches the carry out of the accumulator.
  always_comb begin
    sum_wide = {1'b0, acc_q} + (ACC_W+1)'({carry, result});
    add_ovf  = sum_wide[ACC_W];
`ifdef ACC_SATURATE_EN
    // After one overflow the batch stays pinned at full scale.
    acc_d    = (add_ovf || ovf_q) ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    acc_d    = sum_wide[ACC_W-1:0];
`endif
  end

  assign accept      = in_valid && in_ready_q;
  assign last_accept = (count_q == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (clr) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_q   <= acc_d;
            count_q <= count_q + CNT_W'(1);
            ovf_q   <= ovf_q | add_ovf;
            if (last_accept) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          // in_valid is ignored here. Only the output handshake leaves HOLD,
          // and no sample is taken in the handshake cycle.
          if (out_valid_q && out_ready) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          acc_q       <= '0;
          count_q     <= '0;
          ovf_q       <= 1'b0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;
  assign count     = count_q;

endmodule

// File: tb/tb_add_result_acc.sv
// Testbench for add_result_acc. It drives three instances from shared inputs:
//   0: ACC_W=8, N=4   1: ACC_W=6, N=4   2: ACC_W=8, N=1
// Expected values come from a batch-total model: an unbounded integer total
// that is mapped onto the accumulator width.
module tb_add_result_acc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] result = 4'd0;
  logic       carry = 1'b0;
  logic       clr = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready_a, out_valid_a, ovf_a;
  logic [7:0] acc_a;
  logic [2:0] count_a;
  logic       in_ready_b, out_valid_b, ovf_b;
  logic [5:0] acc_b;
  logic [2:0] count_b;
  logic       in_ready_c, out_valid_c, ovf_c;
  logic [7:0] acc_c;
  logic [0:0] count_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  add_result_acc #(.ACC_W(8), .N(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .result(result), .carry(carry), .clr(clr), .out_valid(out_valid_a),
    .out_ready(out_ready), .acc_out(acc_a), .ovf(ovf_a), .count(count_a));

  add_result_acc #(.ACC_W(6), .N(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .result(result), .carry(carry), .clr(clr), .out_valid(out_valid_b),
    .out_ready(out_ready), .acc_out(acc_b), .ovf(ovf_b), .count(count_b));

  add_result_acc #(.ACC_W(8), .N(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .result(result), .carry(carry), .clr(clr), .out_valid(out_valid_c),
    .out_ready(out_ready), .acc_out(acc_c), .ovf(ovf_c), .count(count_c));

  // Uniform views of the three instances
  logic       rdy_v[3], vld_v[3], ovf_v[3];
  logic [7:0] acc_v[3];
  logic [2:0] cnt_v[3];
  always_comb begin
    rdy_v[0] = in_ready_a;  vld_v[0] = out_valid_a; ovf_v[0] = ovf_a;
    acc_v[0] = acc_a;       cnt_v[0] = count_a;
    rdy_v[1] = in_ready_b;  vld_v[1] = out_valid_b; ovf_v[1] = ovf_b;
    acc_v[1] = {2'b00, acc_b}; cnt_v[1] = count_b;
    rdy_v[2] = in_ready_c;  vld_v[2] = out_valid_c; ovf_v[2] = ovf_c;
    acc_v[2] = acc_c;       cnt_v[2] = {2'b00, count_c};
  end

  // ---------------- reference model ----------------
  int m_tot[3];
  int m_cnt[3];
  bit m_hold[3];

  function automatic int nn(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int ww(input int i);
    return (i == 1) ? 6 : 8;
  endfunction

  function automatic int exp_acc(input int i);
    int mx;
    mx = (1 << ww(i)) - 1;
    if (m_tot[i] > mx) begin
`ifdef ACC_SATURATE_EN
      return mx;
`else
      return m_tot[i] % (mx + 1);
`endif
    end
    return m_tot[i];
  endfunction

  function automatic bit exp_ovf(input int i);
    return m_tot[i] > ((1 << ww(i)) - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n || clr) begin
        m_tot[i] <= 0; m_cnt[i] <= 0; m_hold[i] <= 1'b0;
      end else if (m_hold[i]) begin
        if (out_ready) begin
          m_tot[i] <= 0; m_cnt[i] <= 0; m_hold[i] <= 1'b0;
        end
      end else if (in_valid) begin
        m_tot[i] <= m_tot[i] + int'({carry, result});
        m_cnt[i] <= m_cnt[i] + 1;
        if (m_cnt[i] + 1 == nn(i)) m_hold[i] <= 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] s);
    in_valid = 1'b1;
    {carry, result} = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic clear_all();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (vld_v[i] !== 1'b0 || acc_v[i] !== 8'd0 || cnt_v[i] !== 3'd0 || ovf_v[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got vld=%b acc=%h cnt=%0d ovf=%b, need 0/00/0/0",
                 i, vld_v[i], acc_v[i], cnt_v[i], ovf_v[i]);
      end
    end
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy_v[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready dut%0d: got in_ready=%b, need 1", i, rdy_v[i]);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    clear_all();
    send(5'h0A);
    checks++;
    if (vld_v[2] !== 1'b1 || acc_v[2] !== 8'h0A || rdy_v[2] !== 1'b0) begin
      errors++;
      $display("FAIL n1_hold: got vld=%b acc=%h rdy=%b, need 1/0a/0", vld_v[2], acc_v[2], rdy_v[2]);
    end
    send(5'h0C);
    send(5'h1D);
    checks++;
    if (vld_v[0] !== 1'b0 || cnt_v[0] !== 3'd3 || rdy_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_partial: got vld=%b cnt=%0d rdy=%b, need 0/3/1", vld_v[0], cnt_v[0], rdy_v[0]);
    end
    send(5'h01);
    checks++;
    if (vld_v[0] !== 1'b1 || acc_v[0] !== 8'h34 || ovf_v[0] !== 1'b0 || cnt_v[0] !== 3'd4) begin
      errors++;
      $display("FAIL basic_total: got vld=%b acc=%h ovf=%b cnt=%0d, need 1/34/0/4",
               vld_v[0], acc_v[0], ovf_v[0], cnt_v[0]);
    end
    checks++;
    if (acc_v[1] !== 8'h34 || ovf_v[1] !== 1'b0) begin
      errors++;
      $display("FAIL basic_w6: got acc=%h ovf=%b, need 34/0", acc_v[1], ovf_v[1]);
    end
    handshake();
    checks++;
    if (vld_v[0] !== 1'b0 || cnt_v[0] !== 3'd0 || rdy_v[0] !== 1'b1 || acc_v[0] !== 8'd0) begin
      errors++;
      $display("FAIL basic_handshake: got vld=%b cnt=%0d rdy=%b acc=%h, need 0/0/1/00",
               vld_v[0], cnt_v[0], rdy_v[0], acc_v[0]);
    end
    $display("test_basic done");
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b;
`ifdef ACC_SATURATE_EN
    exp_b = 8'h3F;
`else
    exp_b = 8'h3C;
`endif
    clear_all();
    repeat (4) send(5'h1F);
    checks++;
    if (vld_v[1] !== 1'b1 || acc_v[1] !== exp_b || ovf_v[1] !== 1'b1) begin
      errors++;
      $display("FAIL overflow_w6: got vld=%b acc=%h ovf=%b, need 1/%h/1", vld_v[1], acc_v[1], ovf_v[1], exp_b);
    end
    checks++;
    if (acc_v[0] !== 8'h7C || ovf_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL overflow_w8: got acc=%h ovf=%b, need 7c/0", acc_v[0], ovf_v[0]);
    end
    handshake();
    checks++;
    if (ovf_v[1] !== 1'b0 || acc_v[1] !== 8'd0) begin
      errors++;
      $display("FAIL overflow_clear: got ovf=%b acc=%h, need 0/00", ovf_v[1], acc_v[1]);
    end
    $display("test_overflow done");
  endtask

  task automatic test_hold_stall();
    int tot = 0;
    logic [4:0] s;
    clear_all();
    for (int k = 0; k < 4; k++) begin
      s = 5'($urandom_range(0, 31));
      tot += int'(s);
      send(s);
    end
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      {carry, result} = 5'($urandom);
      tick();
      checks++;
      if (acc_v[0] !== 8'(tot) || cnt_v[0] !== 3'd4 || rdy_v[0] !== 1'b0 || vld_v[0] !== 1'b1) begin
        errors++;
        $display("FAIL hold_stall cyc%0d: got acc=%h cnt=%0d rdy=%b vld=%b, need %h/4/0/1",
                 c, acc_v[0], cnt_v[0], rdy_v[0], vld_v[0], 8'(tot));
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (vld_v[0] !== 1'b0 || cnt_v[0] !== 3'd0 || rdy_v[0] !== 1'b1 || acc_v[0] !== 8'd0) begin
      errors++;
      $display("FAIL hold_release: got vld=%b cnt=%0d rdy=%b acc=%h, need 0/0/1/00",
               vld_v[0], cnt_v[0], rdy_v[0], acc_v[0]);
    end
    $display("test_hold_stall done total=%0d", tot);
  endtask

  task automatic test_clr();
    clear_all();
    send(5'd3);
    send(5'd5);
    checks++;
    if (cnt_v[0] !== 3'd2 || acc_v[0] !== 8'd8) begin
      errors++;
      $display("FAIL clr_pre: got cnt=%0d acc=%h, need 2/08", cnt_v[0], acc_v[0]);
    end
    in_valid = 1'b1;
    {carry, result} = 5'd7;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (cnt_v[0] !== 3'd0 || acc_v[0] !== 8'd0 || ovf_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL clr_priority: got cnt=%0d acc=%h ovf=%b, need 0/00/0", cnt_v[0], acc_v[0], ovf_v[0]);
    end
    for (int k = 1; k <= 4; k++) send(5'(k));
    checks++;
    if (vld_v[0] !== 1'b1 || acc_v[0] !== 8'h0A) begin
      errors++;
      $display("FAIL clr_next_batch: got vld=%b acc=%h, need 1/0a", vld_v[0], acc_v[0]);
    end
    handshake();
    $display("test_clr done");
  endtask

  task automatic test_reset_in_hold();
    clear_all();
    for (int k = 0; k < 4; k++) send(5'($urandom_range(1, 31)));
    checks++;
    if (vld_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_hold_pre: got vld=%b, need 1", vld_v[0]);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (vld_v[i] !== 1'b0 || acc_v[i] !== 8'd0 || cnt_v[i] !== 3'd0) begin
        errors++;
        $display("FAIL rst_hold_async dut%0d: got vld=%b acc=%h cnt=%0d, need 0/00/0",
                 i, vld_v[i], acc_v[i], cnt_v[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (rdy_v[0] !== 1'b1 || vld_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold_release: got rdy=%b vld=%b, need 1/0", rdy_v[0], vld_v[0]);
    end
    $display("test_reset_in_hold done");
  endtask

  task automatic test_gaps();
    logic [4:0] smp[4];
    int tot = 0;
    logic [7:0] b2b;
    for (int k = 0; k < 4; k++) begin
      smp[k] = 5'($urandom);
      tot += int'(smp[k]);
    end
    clear_all();
    for (int k = 0; k < 4; k++) send(smp[k]);
    b2b = acc_v[0];
    checks++;
    if (b2b !== 8'(tot) || vld_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL gaps_b2b: got acc=%h vld=%b, need %h/1", b2b, vld_v[0], 8'(tot));
    end
    handshake();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat ($urandom_range(1, 3)) tick();
      send(smp[k]);
    end
    checks++;
    if (acc_v[0] !== 8'(tot) || vld_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL gaps_spaced: got acc=%h vld=%b, need %h/1", acc_v[0], vld_v[0], 8'(tot));
    end
    handshake();
    $display("test_gaps done total=%0d", tot);
  endtask

  task automatic test_random();
    int bad = 0;
    clear_all();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      {carry, result} = 5'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      clr       = ($urandom_range(0, 39) == 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (acc_v[i] !== 8'(exp_acc(i)) || ovf_v[i] !== exp_ovf(i) ||
            cnt_v[i] !== 3'(m_cnt[i]) || vld_v[i] !== m_hold[i] || rdy_v[i] !== !m_hold[i]) begin
          errors++;
          bad++;
          $display("FAIL random cyc%0d dut%0d: got acc=%h ovf=%b cnt=%0d vld=%b rdy=%b, need %h/%b/%0d/%b/%b",
                   c, i, acc_v[i], ovf_v[i], cnt_v[i], vld_v[i], rdy_v[i],
                   8'(exp_acc(i)), exp_ovf(i), m_cnt[i], m_hold[i], !m_hold[i]);
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    $display("test_random done mismatching_cycles=%0d", bad);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_hold_stall();
    test_clr();
    test_reset_in_hold();
    test_gaps();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

endmodule
